// File: rtl/sdf_r2_stage_if.sv
// Input handshake, twiddle ROM port and output bus of one radix-2 SDF FFT stage.
// The slave modport is the stage side; the master modport is the surrounding pipeline.
interface sdf_r2_stage_if #(
  parameter int W  = 22,
  parameter int AW = 6
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] din_real;
  logic signed [W-1:0] din_imag;
  logic [AW-1:0]       rom_addr;
  logic signed [W-1:0] rom_real;
  logic signed [W-1:0] rom_imag;
  logic                out_valid;
  logic signed [W-1:0] dout_real;
  logic signed [W-1:0] dout_imag;

  modport slave (
    input  in_valid, din_real, din_imag, rom_real, rom_imag,
    output in_ready, rom_addr, out_valid, dout_real, dout_imag
  );

  modport master (
    output in_valid, din_real, din_imag, rom_real, rom_imag,
    input  in_ready, rom_addr, out_valid, dout_real, dout_imag
  );
endinterface

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path-delay-feedback DIF butterfly stage with twiddle multiply.
// Phase A stores inputs (and emits stored diffs); phase B emits sums and stores diffs.
module sdf_r2_stage #(
  parameter int W     = 22,
  parameter int FRAC  = 6,
  parameter int DEPTH = 8,
  parameter int N     = 32,
  parameter int AW    = 6,
  parameter int ABASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  sdf_r2_stage_if.slave bus
);
  localparam int CW = $clog2(2 * DEPTH);
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(2 * DEPTH - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_FILL  = CW'(DEPTH - 1);
  localparam logic [OW-1:0] IDX_LAST  = OW'(N - 1);
  localparam logic [DW-1:0] DRN_LAST  = DW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_in_cnt, w_in_cnt_nxt, w_in_cnt_inc;
  logic [OW-1:0]       r_out_idx;
  logic [DW-1:0]       r_drain_cnt, w_drain_cnt_nxt;
  logic signed [W-1:0] r_dl_re [DEPTH];
  logic signed [W-1:0] r_dl_im [DEPTH];
  logic                w_accept, w_push, w_emit, w_phase_b;
  logic signed [W-1:0] w_head_re, w_head_im;
  logic signed [W-1:0] w_push_re, w_push_im;
  logic signed [W-1:0] w_b_re, w_b_im;
  logic                r_out_valid;
  logic signed [W-1:0] r_dout_re, r_dout_im;

  // Full-width complex product, arithmetic shift, then plain truncation to W bits.
  function automatic logic signed [W-1:0] twiddle_re(
    input logic signed [W-1:0] br, bi, tr, ti
  );
    logic signed [2*W-1:0] p;
    p = (2*W)'(br) * (2*W)'(tr) - (2*W)'(bi) * (2*W)'(ti);
    return W'(p >>> FRAC);
  endfunction

  function automatic logic signed [W-1:0] twiddle_im(
    input logic signed [W-1:0] br, bi, tr, ti
  );
    logic signed [2*W-1:0] p;
    p = (2*W)'(br) * (2*W)'(ti) + (2*W)'(bi) * (2*W)'(tr);
    return W'(p >>> FRAC);
  endfunction

  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_phase_b    = (r_in_cnt >= CNT_HALF);
  assign w_in_cnt_inc = (r_in_cnt == CNT_LAST) ? '0 : r_in_cnt + CW'(1);
  assign w_head_re    = r_dl_re[DEPTH-1];
  assign w_head_im    = r_dl_im[DEPTH-1];

  assign bus.in_ready  = (r_state != S_DRAIN);
  assign bus.rom_addr  = AW'(int'(r_out_idx) + ABASE);
  assign bus.out_valid = r_out_valid;
  assign bus.dout_real = r_dout_re;
  assign bus.dout_imag = r_dout_im;

  always_comb begin
    w_state_nxt     = r_state;
    w_in_cnt_nxt    = r_in_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_push          = 1'b0;
    w_push_re       = bus.din_real;
    w_push_im       = bus.din_imag;
    w_emit          = 1'b0;
    w_b_re          = w_head_re;
    w_b_im          = w_head_im;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_push       = 1'b1;
          w_in_cnt_nxt = w_in_cnt_inc;
          w_state_nxt  = S_FILL;
        end
      end
      S_FILL: begin
        if (w_accept) begin
          w_push       = 1'b1;
          w_in_cnt_nxt = w_in_cnt_inc;
          if (r_in_cnt == CNT_FILL) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          w_push       = 1'b1;
          w_emit       = 1'b1;
          w_in_cnt_nxt = w_in_cnt_inc;
          if (w_phase_b) begin
            w_b_re    = w_head_re + bus.din_real;
            w_b_im    = w_head_im + bus.din_imag;
            w_push_re = w_head_re - bus.din_real;
            w_push_im = w_head_im - bus.din_imag;
          end
        end else if (r_in_cnt == '0) begin
          // Idle at a group boundary: flush the stored diffs.
          w_state_nxt     = S_DRAIN;
          w_drain_cnt_nxt = '0;
        end
      end
      S_DRAIN: begin
        w_push    = 1'b1;
        w_push_re = '0;
        w_push_im = '0;
        w_emit    = 1'b1;
        if (r_drain_cnt == DRN_LAST) begin
          w_state_nxt     = S_IDLE;
          w_drain_cnt_nxt = '0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + DW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_cnt    <= '0;
      r_drain_cnt <= '0;
      r_out_idx   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_cnt    <= w_in_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      if (w_emit) r_out_idx <= (r_out_idx == IDX_LAST) ? '0 : r_out_idx + OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
      end
    end else if (w_push) begin
      r_dl_re[0] <= w_push_re;
      r_dl_im[0] <= w_push_im;
      for (int i = 1; i < DEPTH; i++) begin
        r_dl_re[i] <= r_dl_re[i-1];
        r_dl_im[i] <= r_dl_im[i-1];
      end
    end
  end

  // Output register: twiddled butterfly result appears one cycle after it is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_dout_re   <= '0;
      r_dout_im   <= '0;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_dout_re <= twiddle_re(w_b_re, w_b_im, bus.rom_real, bus.rom_imag);
        r_dout_im <= twiddle_im(w_b_re, w_b_im, bus.rom_real, bus.rom_imag);
      end
    end
  end
endmodule
